tri_stream_drv: RTL

TRI_STREAM_DRV -- requirements
Module: tri_stream_drv

---
 rtl/rast_pkg.sv | 44 ++++
 rtl/tri_fifo.sv | 62 ++++++
 rtl/tri_stream_drv.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/rast_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rast_pkg
//  Description : Shared types and sizing for the triangle stream driver.
//                Holds the geometry/colour widths, the packed triangle
//                entry carried through the buffer, the driver state enum
//                and a saturating counter helper.
//  Revision    : 1.0  initial release
// ============================================================================
package rast_pkg;

    localparam int SIGFIG = 24;   // bits per coordinate / colour channel
    localparam int RADIX  = 10;   // fraction bits in a coordinate
    localparam int VERTS  = 3;    // vertices per triangle
    localparam int AXIS   = 3;    // axes per vertex (x, y, z)
    localparam int COLORS = 3;    // colour channels

    typedef logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_pos_t;
    typedef logic        [COLORS-1:0][SIGFIG-1:0]          tri_color_t;

    // One buffered triangle. The last flag rides with its triangle so the
    // frame end is recognised when that exact triangle leaves the block.
    typedef struct packed {
        tri_pos_t   tri_pos;
        tri_color_t color;
        logic       last;
    } tri_entry_t;

    localparam int ENTRY_W = $bits(tri_entry_t);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } drv_state_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : (v + 32'd1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/tri_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tri_fifo
//  Description : Synchronous FIFO for triangle entries. Pointers carry one
//                extra wrap bit, so equal pointers mean empty and pointers
//                differing only in the wrap bit mean full.
//  Ports       : clk, rst (async, active-low)
//                push/din   - write side, ignored when full
//                pop/dout   - read side, dout shows the head, ignored when empty
//                full/empty - occupancy flags derived from registered pointers
//  Revision    : 1.0  initial release
// ============================================================================
module tri_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             push_ok;
    logic             pop_ok;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // Guarding here makes overflow/underflow impossible whatever the caller does.
    assign push_ok = push && !full;
    assign pop_ok  = pop  && !empty;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
        end
    end

    // Storage needs no reset: occupancy is defined purely by the pointers.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= din;
    end

    assign dout = mem_q[rd_ptr_q[AW-1:0]];

endmodule
`default_nettype wire

// File: rtl/tri_stream_drv.sv
`default_nettype none
// ============================================================================
//  Module      : tri_stream_drv
//  Description : Buffers host triangles and streams them to the rasterizer
//                one per cycle through a registered R10 output stage that
//                holds while the rasterizer halts. A small frame FSM
//                (IDLE/RUN/DRAIN/DONE) gates host intake, latches the frame
//                configuration and counts consumed triangles.
//  Ports       : clk, rst (async, active-low)
//                start, cfg_screen, cfg_subSample - frame launch + config
//                in_valid/in_ready/in_tri/in_color/in_last - host stream
//                halt_RnnnnL - low stalls the rasterizer
//                tri_R10S/color_R10U/validTri_R10H - rasterizer stream
//                screen_RnnnnS/subSample_RnnnnU - latched configuration
//                busy, done, tri_count - frame status
//  Revision    : 1.0  initial release
// ============================================================================
module tri_stream_drv #(
    parameter int SIGFIG     = rast_pkg::SIGFIG,
    parameter int RADIX      = rast_pkg::RADIX,
    parameter int VERTS      = rast_pkg::VERTS,
    parameter int AXIS       = rast_pkg::AXIS,
    parameter int COLORS     = rast_pkg::COLORS,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          start,
    input  logic signed [1:0][SIGFIG-1:0]                 cfg_screen,
    input  logic        [3:0]                             cfg_subSample,
    input  logic                                          in_valid,
    output logic                                          in_ready,
    input  logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] in_tri,
    input  logic        [COLORS-1:0][SIGFIG-1:0]          in_color,
    input  logic                                          in_last,
    input  logic                                          halt_RnnnnL,
    output logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R10S,
    output logic        [COLORS-1:0][SIGFIG-1:0]          color_R10U,
    output logic                                          validTri_R10H,
    output logic signed [1:0][SIGFIG-1:0]                 screen_RnnnnS,
    output logic        [3:0]                             subSample_RnnnnU,
    output logic                                          busy,
    output logic                                          done,
    output logic        [31:0]                            tri_count
);

    import rast_pkg::*;

    // ------------------------------------------------------------------
    // Elaboration guards: the entry struct is sized by the package, so
    // the module geometry must agree with it.
    // ------------------------------------------------------------------
    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("tri_stream_drv: FIFO_DEPTH must be a power of two and at least 2");
    end

    if ((SIGFIG != rast_pkg::SIGFIG) || (RADIX != rast_pkg::RADIX) ||
        (VERTS != rast_pkg::VERTS) || (AXIS != rast_pkg::AXIS) ||
        (COLORS != rast_pkg::COLORS) || (RADIX >= SIGFIG)) begin : g_bad_geometry
        $error("tri_stream_drv: geometry parameters disagree with rast_pkg");
    end

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
    drv_state_t                  state_q;
    drv_state_t                  state_d;
    tri_entry_t                  out_q;          // R10 output stage
    logic                        out_valid_q;
    logic signed [1:0][SIGFIG-1:0] screen_q;
    logic [3:0]                  subsample_q;
    logic [31:0]                 count_q;
    logic                        busy_q;
    logic                        done_q;

    tri_entry_t                  push_entry;
    tri_entry_t                  head_entry;
    logic                        fifo_full;
    logic                        fifo_empty;
    logic                        fifo_push;
    logic                        fifo_pop;
    logic                        start_ok;
    logic                        consume;
    logic                        load_out;

    // ------------------------------------------------------------------
    // Handshakes
    // ------------------------------------------------------------------
    // in_ready comes only from registered state, so a pop in the current
    // cycle cannot open the door for a push in the same cycle.
    assign in_ready  = (state_q == ST_RUN) && !fifo_full;
    assign fifo_push = in_valid && in_ready;

    assign consume   = out_valid_q && halt_RnnnnL;
    // The output stage refills when it is empty or its content is leaving,
    // which sustains one triangle per cycle.
    assign load_out  = !out_valid_q || consume;
    assign fifo_pop  = load_out && !fifo_empty;

    assign start_ok  = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

    assign push_entry.tri_pos = in_tri;
    assign push_entry.color   = in_color;
    assign push_entry.last    = in_last;

    // ------------------------------------------------------------------
    // Triangle buffer
    // ------------------------------------------------------------------
    tri_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_tri_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .din   (push_entry),
        .pop   (fifo_pop),
        .dout  (head_entry),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // ------------------------------------------------------------------
    // Frame state next-state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE,
            ST_DONE:  if (start_ok) state_d = ST_RUN;
            ST_RUN:   if (fifo_push && in_last) state_d = ST_DRAIN;
            // Only the tagged triangle leaving the output stage ends the frame.
            ST_DRAIN: if (consume && out_q.last) state_d = ST_DONE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State, output stage, configuration and counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            screen_q    <= '0;
            subsample_q <= '0;
            count_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d == ST_RUN) || (state_d == ST_DRAIN);
            done_q  <= (state_d == ST_DONE);

            if (start_ok) begin
                screen_q    <= cfg_screen;
                subsample_q <= cfg_subSample;
            end

            if (start_ok) begin
                count_q <= '0;
            end else if (consume) begin
                count_q <= sat_inc32(count_q);
            end

            // Data only moves on a load; while halted with valid data the
            // whole stage, including the valid bit, is left untouched.
            if (load_out) begin
                out_valid_q <= !fifo_empty;
                if (!fifo_empty) out_q <= head_entry;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign tri_R10S         = out_q.tri_pos;
    assign color_R10U       = out_q.color;
    assign validTri_R10H    = out_valid_q;
    assign screen_RnnnnS    = screen_q;
    assign subSample_RnnnnU = subsample_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign tri_count        = count_q;

endmodule
`default_nettype wire
